// File: rtl/tawas_ls_wait_if.sv
// Request, data-bus and regfile-writeback signals of the Tawas wait-state load/store unit.
// master = core/bus environment side, slave = the load/store unit.
interface tawas_ls_wait_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int RW = 4
);
  logic            req_vld;
  logic            req_rdy;
  logic            req_wr;
  logic [1:0]      req_size;
  logic            req_sext;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data;
  logic [RW-1:0]   req_reg;
  logic            req_err;
  logic [AW-1:0]   daddr;
  logic            dcs;
  logic            raccoon_cs;
  logic            dwr;
  logic [DW/8-1:0] dmask;
  logic [DW-1:0]   dout;
  logic            drdy;
  logic            din_vld;
  logic [DW-1:0]   din;
  logic            ls_load_vld;
  logic [RW-1:0]   ls_load_sel;
  logic [DW-1:0]   ls_load;

  modport master (
    output req_vld, req_wr, req_size, req_sext, req_addr, req_data, req_reg,
    output drdy, din_vld, din,
    input  req_rdy, req_err, daddr, dcs, raccoon_cs, dwr, dmask, dout,
    input  ls_load_vld, ls_load_sel, ls_load
  );

  modport slave (
    input  req_vld, req_wr, req_size, req_sext, req_addr, req_data, req_reg,
    input  drdy, din_vld, din,
    output req_rdy, req_err, daddr, dcs, raccoon_cs, dwr, dmask, dout,
    output ls_load_vld, ls_load_sel, ls_load
  );
endinterface

// File: rtl/tawas_ls_wait.sv
// Tawas load/store unit for wait-state D/Raccoon buses: bus request 1 cycle after accept, held until DRDY;
// up to DEPTH in-order loads tracked, writeback 1 cycle after DIN_VLD. Define TAWAS_LS_SEXT_EN for load sign extension.
module tawas_ls_wait #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int RW          = 4,
  parameter int DEPTH       = 4,
  parameter int RACCOON_LSB = 20
) (
  input logic            clk_i,
  input logic            rst_i,
  tawas_ls_wait_if.slave ls
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RW-1:0] sel;
    logic [1:0]    size;
    logic [LB-1:0] off;
`ifdef TAWAS_LS_SEXT_EN
    logic          sext;
`endif
  } tag_t;

  logic          dcs_q, rac_q, dwr_q, err_q;
  logic [NB-1:0] dmask_q, dmask_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [AW-1:0] daddr_q;
  logic          ld_vld_q;
  logic [RW-1:0] ld_sel_q;
  logic [DW-1:0] ld_dat_q, ld_dat_d;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  tag_t          fifo_q [DEPTH];
  tag_t          tag_d, tag_rd;

  logic          busy, req_acc, legal, issue, push, pop, orphan, is_rac, ext, ld_msb;
  logic [LB-1:0] lane;
  logic [DW-1:0] ld_sh, ld_keep;

  assign busy       = dcs_q | rac_q;
  assign ls.req_rdy = (!busy || ls.drdy) && (cnt_q != CW'(DEPTH));
  assign req_acc    = ls.req_vld && ls.req_rdy;
  assign lane       = ls.req_addr[LB-1:0];
  assign is_rac     = (ls.req_addr >> RACCOON_LSB) != '0;
  assign issue      = req_acc && legal;
  assign push       = issue && !ls.req_wr;
  assign pop        = ls.din_vld && (cnt_q != '0);
  assign orphan     = ls.din_vld && (cnt_q == '0);

  // Lane mask and store replication are both driven by the access size.
  always_comb begin
    legal   = 1'b0;
    dmask_d = '0;
    dout_d  = ls.req_data;
    case (ls.req_size)
      2'd0: begin
        legal   = 1'b1;
        dmask_d = NB'(1);
        dout_d  = {NB{ls.req_data[7:0]}};
      end
      2'd1: begin
        legal   = !lane[0];
        dmask_d = NB'(3);
        dout_d  = {(NB/2){ls.req_data[15:0]}};
      end
      2'd2: begin
        legal   = (lane[1:0] == 2'b00);
        dmask_d = NB'(15);
        dout_d  = {(NB/4){ls.req_data[31:0]}};
      end
      default: begin
        legal   = (DW == 64) && (lane == '0);
        dmask_d = '1;
      end
    endcase
    dmask_d = dmask_d << lane;
  end

  always_comb begin
    tag_d      = '0;
    tag_d.sel  = ls.req_reg;
    tag_d.size = ls.req_size;
    tag_d.off  = lane;
`ifdef TAWAS_LS_SEXT_EN
    tag_d.sext = ls.req_sext;
`endif
  end

  assign tag_rd = fifo_q[rd_ptr_q];

`ifdef TAWAS_LS_SEXT_EN
  assign ext = tag_rd.sext;
`else
  logic unused_sext;
  assign ext         = 1'b0;
  assign unused_sext = ls.req_sext;
`endif

  // Return data is right-justified by the lane offset captured at issue time.
  always_comb begin
    ld_sh   = ls.din >> {tag_rd.off, 3'b000};
    ld_keep = '1;
    ld_msb  = 1'b0;
    case (tag_rd.size)
      2'd0:    begin ld_keep = DW'(8'hFF);         ld_msb = ld_sh[7];  end
      2'd1:    begin ld_keep = DW'(16'hFFFF);      ld_msb = ld_sh[15]; end
      2'd2:    begin ld_keep = DW'(32'hFFFF_FFFF); ld_msb = ld_sh[31]; end
      default: begin ld_keep = '1;                 ld_msb = 1'b0;      end
    endcase
    ld_dat_d = (ld_sh & ld_keep) | ((ext && ld_msb) ? ~ld_keep : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcs_q    <= 1'b0;
      rac_q    <= 1'b0;
      dwr_q    <= 1'b0;
      dmask_q  <= '0;
      dout_q   <= '0;
      daddr_q  <= '0;
      err_q    <= 1'b0;
      ld_vld_q <= 1'b0;
      ld_sel_q <= '0;
      ld_dat_q <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      err_q <= (req_acc && !legal) || orphan;
      if (issue) begin
        dcs_q   <= !is_rac;
        rac_q   <= is_rac;
        dwr_q   <= ls.req_wr;
        dmask_q <= dmask_d;
        dout_q  <= dout_d;
        daddr_q <= ls.req_addr & ~AW'(NB - 1);
      end else if (busy && ls.drdy) begin
        dcs_q   <= 1'b0;
        rac_q   <= 1'b0;
        dwr_q   <= 1'b0;
        dmask_q <= '0;
        dout_q  <= '0;
        daddr_q <= '0;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= tag_d;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        ld_sel_q <= tag_rd.sel;
        ld_dat_q <= ld_dat_d;
      end
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
      ld_vld_q <= pop;
    end
  end

  assign ls.dcs         = dcs_q;
  assign ls.raccoon_cs  = rac_q;
  assign ls.dwr         = dwr_q;
  assign ls.dmask       = dmask_q;
  assign ls.dout        = dout_q;
  assign ls.daddr       = daddr_q;
  assign ls.req_err     = err_q;
  assign ls.ls_load_vld = ld_vld_q;
  assign ls.ls_load_sel = ld_sel_q;
  assign ls.ls_load     = ld_dat_q;
endmodule
